onehot_decoder_seq: RTL and testbench
=====================================

// Module: onehot_decoder_seq
// PURPOSE
//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder. Adds a
//  valid/ready input handshake and three output modes (HOLD, PULSE, SCAN).
//  Drives strobe/enable fan-out, such as bank selects and row strobes, from
//  a single control source.
// PARAMETERS
//  SEL_W      3   select width; OUT_W = 2**SEL_W (localparam, not overridable)
//  PULSE_CYC  1   cycles dec_out stays high in PULSE mode (>=1)
//  SCAN_DIV   1   cycles per step in SCAN mode (>=1)
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  rst       in   1       synchronous reset, active-high
//  in_valid  in   1       request valid
//  in_ready  out  1       block can accept a request
//  sel       in   SEL_W   index to decode; sampled on accept
//  mode      in   2       00 HOLD, 01 PULSE, 10 SCAN, 11 treated as HOLD
//  clr       in   1       synchronous abort/clear
//  dec_out   out  OUT_W   registered one-hot (or all-zero) output
//  out_idx   out  SEL_W   index of the asserted bit (0 when dec_out==0)
//  busy      out  1       high in PULSE or SCAN state
//  done      out  1       one-cycle pulse when a PULSE or SCAN op completes
// BEHAVIOUR
//  - Reset: state=IDLE, dec_out=0, out_idx=0, busy=0, done=0, counters=0.
//    Reset overrides everything, including in-flight ops.
//  - Accept = in_valid & in_ready at a rising edge.
//  - in_ready = (state==IDLE) & ~clr. It is combinational from state and clr.
//  - Latency: dec_out reflects an accepted sel on the cycle after the
//    accepting edge (1 register stage).
//  - FSM states: IDLE, PULSE, SCAN.
//  - IDLE + accept, HOLD:
//      dec_out <= 1<<sel, out_idx <= sel, stay IDLE.
//      The value holds until the next accept or clr.
//  - IDLE + accept, PULSE:
//      dec_out <= 1<<sel, cnt <= PULSE_CYC-1, go to PULSE.
//  - PULSE state:
//      cnt!=0: cnt--.
//      cnt==0: dec_out<=0, out_idx<=0, done<=1, go to IDLE.
//      dec_out is high for exactly PULSE_CYC cycles.
//  - IDLE + accept, SCAN:
//      dec_out <= 1<<sel, idx <= sel, div <= SCAN_DIV-1, go to SCAN.
//  - SCAN state, at div==0:
//      idx<OUT_W-1: idx++, dec_out <<= 1, div <= SCAN_DIV-1.
//      idx==OUT_W-1: dec_out<=0, out_idx<=0, done<=1, go to IDLE.
//    Each bit sel..OUT_W-1 is high for SCAN_DIV cycles in ascending order.
//    No wrap to bit 0.
//  - done is high only on the first IDLE cycle after completion.
//    A new accept is allowed in that same cycle.
//  - clr, any state: next cycle state=IDLE, dec_out=0, out_idx=0,
//    counters=0, done=0. No request is accepted while clr is high.
//  - clr and in_valid together: clr wins and the request is not accepted.
//    The requester must hold in_valid.
//  - HOLD accept while a HOLD value is present: the output is replaced
//    cleanly in one cycle with no all-zero gap.
//  - dec_out is always one-hot or all-zero; never multi-hot.
//  - Arithmetic: sel is always in range (OUT_W = 2**SEL_W).
//    Counters are sized $clog2(max(PULSE_CYC,SCAN_DIV))+1 bits.
// TESTING
//  - Reset, then HOLD accept sel=5 -> dec_out=8'h20, out_idx=5 next cycle.
//    Value holds 10 cycles with no new accept; busy=0, in_ready=1.
//  - PULSE, PULSE_CYC=3, sel=2 -> dec_out=8'h04 for exactly 3 cycles, then 0.
//    done=1 for 1 cycle; in_ready=0 during the pulse.
//  - SCAN, SCAN_DIV=2, sel=5 -> 8'h20,8'h20,8'h40,8'h40,8'h80,8'h80, then 0.
//    done=1 after the last step.
//  - SCAN from sel=7 -> 8'h80 for SCAN_DIV cycles, then done.
//    clr mid-SCAN -> dec_out=0 next cycle, no done, in_ready=1 after clr drops.
//  - Same-cycle clr and in_valid in IDLE -> not accepted, dec_out stays 0.
//    rst asserted mid-PULSE -> all outputs 0 on the next cycle.
//  - Random mode/sel stream with a one-hot checker on dec_out.
//    Compare against a reference model for SEL_W=2 and SEL_W=4.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with a valid/ready request port
// and three output modes: HOLD (static select), PULSE (timed strobe), SCAN (walking bit).
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | ready for a request; dec_out holds the last HOLD value or zero
//  ST_PULSE | dec_out strobe active, down-counter timing PULSE_CYC cycles
//  ST_SCAN  | walking one-hot from sel up to the MSB, SCAN_DIV cycles per bit
module onehot_decoder_seq #(
    parameter int SEL_W     = 3,
    parameter int PULSE_CYC = 1,
    parameter int SCAN_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    input  logic                  clr,
    output logic [2**SEL_W-1:0]   dec_out,
    output logic [SEL_W-1:0]      out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W   = 2**SEL_W;
    localparam int CNT_MAX = (PULSE_CYC > SCAN_DIV) ? PULSE_CYC : SCAN_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SCAN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   dec_q, dec_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               accept;

    assign in_ready = (state_q == ST_IDLE) & ~clr;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dec_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // One shared down-counter: pulse width in ST_PULSE, step divider in ST_SCAN.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            dec_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dec_d = OUT_W'(1) << sel;
                        idx_d = sel;
                        if (mode == MODE_PULSE) begin
                            cnt_d   = PULSE_LOAD;
                            state_d = ST_PULSE;
                        end else if (mode == MODE_SCAN) begin
                            cnt_d   = SCAN_LOAD;
                            state_d = ST_SCAN;
                        end
                    end
                end

                ST_PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        dec_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                ST_SCAN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (idx_q != IDX_LAST) begin
                        // Shift keeps the output one-hot; no wrap past the MSB.
                        idx_d = idx_q + SEL_W'(1);
                        dec_d = dec_q << 1;
                        cnt_d = SCAN_LOAD;
                    end else begin
                        dec_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    dec_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dec_out = dec_q;
    assign out_idx = idx_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: three instances (SEL_W=3/2/4) with
// hand-computed expectations and a continuous one-hot check on every output.
module tb_onehot_decoder_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  oh_en   = 1'b0;

    // Instance A: SEL_W=3, PULSE_CYC=3, SCAN_DIV=2
    logic       a_valid, a_ready, a_clr, a_busy, a_done;
    logic [2:0] a_sel, a_idx;
    logic [1:0] a_mode;
    logic [7:0] a_dec;

    // Instance B: SEL_W=2, PULSE_CYC=1, SCAN_DIV=1
    logic       b_valid, b_ready, b_clr, b_busy, b_done;
    logic [1:0] b_sel, b_idx;
    logic [1:0] b_mode;
    logic [3:0] b_dec;

    // Instance C: SEL_W=4, PULSE_CYC=2, SCAN_DIV=1
    logic        c_valid, c_ready, c_clr, c_busy, c_done;
    logic [3:0]  c_sel, c_idx;
    logic [1:0]  c_mode;
    logic [15:0] c_dec;

    logic [7:0] scan_dec [6];
    logic [2:0] scan_idx [6];

    onehot_decoder_seq #(.SEL_W(3), .PULSE_CYC(3), .SCAN_DIV(2)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .sel(a_sel), .mode(a_mode), .clr(a_clr), .dec_out(a_dec),
        .out_idx(a_idx), .busy(a_busy), .done(a_done)
    );

    onehot_decoder_seq #(.SEL_W(2), .PULSE_CYC(1), .SCAN_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .sel(b_sel), .mode(b_mode), .clr(b_clr), .dec_out(b_dec),
        .out_idx(b_idx), .busy(b_busy), .done(b_done)
    );

    onehot_decoder_seq #(.SEL_W(4), .PULSE_CYC(2), .SCAN_DIV(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready),
        .sel(c_sel), .mode(c_mode), .clr(c_clr), .dec_out(c_dec),
        .out_idx(c_idx), .busy(c_busy), .done(c_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (oh_en) begin
            chk("onehot_a", 32'($onehot0(a_dec)), 32'd1);
            chk("onehot_b", 32'($onehot0(b_dec)), 32'd1);
            chk("onehot_c", 32'($onehot0(c_dec)), 32'd1);
        end
    end

    initial begin
        scan_dec = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80};
        scan_idx = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};

        rst = 1'b1;
        a_valid = 0; a_sel = 0; a_mode = 0; a_clr = 0;
        b_valid = 0; b_sel = 0; b_mode = 0; b_clr = 0;
        c_valid = 0; c_sel = 0; c_mode = 0; c_clr = 0;
        step();
        step();

        // Reset state
        chk("rst_dec_a", a_dec, 0);
        chk("rst_idx_a", a_idx, 0);
        chk("rst_busy_a", a_busy, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_dec_b", b_dec, 0);
        chk("rst_dec_c", c_dec, 0);
        rst = 1'b0;
        oh_en = 1'b1;
        #1;
        chk("rst_ready_a", a_ready, 1);

        // HOLD sel=5, held for 10 cycles
        a_valid = 1; a_sel = 3'd5; a_mode = 2'b00;
        step();
        a_valid = 0;
        chk("hold_dec", a_dec, 8'h20);
        chk("hold_idx", a_idx, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_keep", a_dec, 8'h20);
            chk("hold_busy", a_busy, 0);
            chk("hold_ready", a_ready, 1);
        end

        // mode 11 acts as HOLD; direct replacement with no zero gap
        a_valid = 1; a_sel = 3'd3; a_mode = 2'b11;
        step();
        a_valid = 0;
        chk("repl_dec", a_dec, 8'h08);
        chk("repl_idx", a_idx, 3);
        chk("repl_busy", a_busy, 0);

        // PULSE sel=2, 3 cycles
        a_valid = 1; a_sel = 3'd2; a_mode = 2'b01;
        step();
        a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("pulse_dec", a_dec, 8'h04);
            chk("pulse_ready", a_ready, 0);
            chk("pulse_busy", a_busy, 1);
            chk("pulse_done", a_done, 0);
            step();
        end
        chk("pulse_end_dec", a_dec, 8'h00);
        chk("pulse_end_idx", a_idx, 0);
        chk("pulse_end_done", a_done, 1);
        chk("pulse_end_busy", a_busy, 0);
        chk("pulse_end_ready", a_ready, 1);
        step();
        chk("pulse_done_drop", a_done, 0);

        // SCAN sel=5, 2 cycles per step
        a_valid = 1; a_sel = 3'd5; a_mode = 2'b10;
        step();
        a_valid = 0;
        for (int i = 0; i < 6; i++) begin
            chk("scan_dec", a_dec, scan_dec[i]);
            chk("scan_idx", a_idx, scan_idx[i]);
            chk("scan_busy", a_busy, 1);
            chk("scan_done", a_done, 0);
            step();
        end
        chk("scan_end_dec", a_dec, 8'h00);
        chk("scan_end_idx", a_idx, 0);
        chk("scan_end_done", a_done, 1);
        step();

        // SCAN from the top bit, then accept in the done cycle
        a_valid = 1; a_sel = 3'd7; a_mode = 2'b10;
        step();
        a_valid = 0;
        chk("scan7_dec0", a_dec, 8'h80);
        step();
        chk("scan7_dec1", a_dec, 8'h80);
        step();
        chk("scan7_end_dec", a_dec, 8'h00);
        chk("scan7_end_done", a_done, 1);
        chk("scan7_end_ready", a_ready, 1);
        a_valid = 1; a_sel = 3'd1; a_mode = 2'b00;
        step();
        a_valid = 0;
        chk("done_accept_dec", a_dec, 8'h02);
        chk("done_accept_idx", a_idx, 1);
        chk("done_accept_done", a_done, 0);

        // clr mid-SCAN, then clr together with a held request
        a_valid = 1; a_sel = 3'd4; a_mode = 2'b10;
        step();
        a_valid = 0;
        chk("clrscan_dec0", a_dec, 8'h10);
        step();
        chk("clrscan_dec1", a_dec, 8'h10);
        step();
        chk("clrscan_dec2", a_dec, 8'h20);
        a_clr = 1; a_valid = 1; a_sel = 3'd6; a_mode = 2'b00;
        #1;
        chk("clr_ready_comb", a_ready, 0);
        step();
        chk("clr_dec", a_dec, 8'h00);
        chk("clr_idx", a_idx, 0);
        chk("clr_busy", a_busy, 0);
        chk("clr_done", a_done, 0);
        chk("clr_ready", a_ready, 0);
        step();
        chk("clrvalid_dec", a_dec, 8'h00);
        chk("clrvalid_done", a_done, 0);
        a_clr = 0;
        #1;
        chk("clr_drop_ready", a_ready, 1);
        step();
        a_valid = 0;
        chk("held_req_dec", a_dec, 8'h40);
        chk("held_req_idx", a_idx, 6);

        // rst mid-PULSE
        a_valid = 1; a_sel = 3'd6; a_mode = 2'b01;
        step();
        a_valid = 0;
        chk("rstp_dec0", a_dec, 8'h40);
        step();
        chk("rstp_dec1", a_dec, 8'h40);
        rst = 1;
        step();
        chk("rstp_dec", a_dec, 8'h00);
        chk("rstp_idx", a_idx, 0);
        chk("rstp_busy", a_busy, 0);
        chk("rstp_done", a_done, 0);
        rst = 0;
        step();
        chk("rstp_after_done", a_done, 0);
        chk("rstp_after_dec", a_dec, 8'h00);

        // Instance B: SEL_W=2 scan from 1, then pulse in the done cycle
        b_valid = 1; b_sel = 2'd1; b_mode = 2'b10;
        step();
        b_valid = 0;
        chk("b_scan0", b_dec, 4'h2);
        chk("b_scan0_idx", b_idx, 1);
        step();
        chk("b_scan1", b_dec, 4'h4);
        step();
        chk("b_scan2", b_dec, 4'h8);
        chk("b_scan2_idx", b_idx, 3);
        step();
        chk("b_scan_end", b_dec, 4'h0);
        chk("b_scan_done", b_done, 1);
        b_valid = 1; b_sel = 2'd3; b_mode = 2'b01;
        step();
        b_valid = 0;
        chk("b_pulse_dec", b_dec, 4'h8);
        chk("b_pulse_busy", b_busy, 1);
        chk("b_pulse_ready", b_ready, 0);
        step();
        chk("b_pulse_end", b_dec, 4'h0);
        chk("b_pulse_done", b_done, 1);

        // Instance C: SEL_W=4 hold, scan near the top, pulse of 2
        c_valid = 1; c_sel = 4'd9; c_mode = 2'b00;
        step();
        chk("c_hold_dec", c_dec, 16'h0200);
        chk("c_hold_idx", c_idx, 9);
        c_sel = 4'd14; c_mode = 2'b10;
        step();
        c_valid = 0;
        chk("c_scan0", c_dec, 16'h4000);
        chk("c_scan0_idx", c_idx, 14);
        step();
        chk("c_scan1", c_dec, 16'h8000);
        chk("c_scan1_idx", c_idx, 15);
        step();
        chk("c_scan_end", c_dec, 16'h0000);
        chk("c_scan_done", c_done, 1);
        c_valid = 1; c_sel = 4'd0; c_mode = 2'b01;
        step();
        c_valid = 0;
        chk("c_pulse0", c_dec, 16'h0001);
        chk("c_pulse_busy", c_busy, 1);
        step();
        chk("c_pulse1", c_dec, 16'h0001);
        step();
        chk("c_pulse_end", c_dec, 16'h0000);
        chk("c_pulse_done", c_done, 1);
        chk("c_pulse_ready", c_ready, 1);
        step();

        oh_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
